// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared types and constants for the bit-serial adder sequencer.
//            - state_e       : sequencer FSM state encoding
//            - DEFAULT_WIDTH : default operand/result width
//            - LOAD_CYCLES   : cycles the adder cell needs to preload carry
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // The adder cell takes one strobed cycle to load its carry flop.
    localparam int LOAD_CYCLES = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/serial_add_shreg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_shreg
// Purpose  : WIDTH-bit right-shift register with parallel load.
//            Parallel load has priority over shift.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active-high (clears to 0)
//            load_i     - parallel load strobe
//            load_val_i - parallel load value
//            shift_i    - shift right by one, shift_in_i enters at MSB
//            shift_in_i - serial input bit
//            q_o        - register contents
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_shreg
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             shift_in_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_val_i;
        end else if (shift_i) begin
            data_d = {shift_in_i, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : serial_add_shreg
`default_nettype wire

// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_seq
// Purpose  : Sequencer for a bit-serial adder cell. Accepts a parallel
//            WIDTH-bit add request, preloads the cell carry with cin, streams
//            operand bits LSB-first (one per clock), collects the serial sum
//            and returns sum + final carry with a one-cycle done pulse.
//            Latency: accept edge k -> done in cycle k+WIDTH+1.
// Ports    : CLK, rst (async, active-high)
//            req, op_a, op_b, cin        - request side (sampled in IDLE only)
//            busy, done, sum, cout       - response side (sum/cout held)
//            sa_A, sa_B, sa_CIN, sa_start - drive to adder cell
//            sa_S, sa_COUT               - from adder cell
//            ovf                         - two's-complement overflow
//                                          (only when SERIAL_ADD_OVF_EN defined)
// Options  : `define SERIAL_ADD_OVF_EN adds the registered ovf output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             sa_A,
    output logic             sa_B,
    output logic             sa_CIN,
    output logic             sa_start,
    input  logic             sa_S,
    input  logic             sa_COUT
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cin_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [WIDTH-1:0] sum_out_q;
    logic             cout_q;

    logic             accept;
    logic             shifting;
    logic             last_shift;
    logic             carry_out;
    logic [WIDTH-1:0] sum_final;
    logic             unused_bits;

    assign accept     = (state_q == ST_IDLE) && req;
    assign shifting   = (state_q == ST_SHIFT);
    assign last_shift = shifting && (cnt_q == CNT_LAST);

    // The cell only registers the carry out of the MSB at the same edge we
    // leave SHIFT, so both the last sum bit and the final carry are formed
    // here from the cell's current inputs to have them valid during DONE.
    assign carry_out = (a_q[0] & b_q[0]) | (sa_COUT & (a_q[0] ^ b_q[0]));
    assign sum_final = {sa_S, sum_q[WIDTH-1:1]};

    // Only the LSBs of the operand registers and the upper sum bits are read.
    assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1], sum_q[0]};

    serial_add_shreg #(.WIDTH(WIDTH)) u_a_shreg (
        .clk        (CLK),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (op_a),
        .shift_i    (shifting),
        .shift_in_i (1'b0),
        .q_o        (a_q)
    );

    serial_add_shreg #(.WIDTH(WIDTH)) u_b_shreg (
        .clk        (CLK),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (op_b),
        .shift_i    (shifting),
        .shift_in_i (1'b0),
        .q_o        (b_q)
    );

    serial_add_shreg #(.WIDTH(WIDTH)) u_sum_shreg (
        .clk        (CLK),
        .rst        (rst),
        .load_i     (1'b0),
        .load_val_i ({WIDTH{1'b0}}),
        .shift_i    (shifting),
        .shift_in_i (sa_S),
        .q_o        (sum_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy     = 1'b1;
        done     = 1'b0;
        sa_A     = 1'b0;
        sa_B     = 1'b0;
        sa_CIN   = 1'b0;
        sa_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sa_start = 1'b1;
                sa_CIN   = cin_q;
                cnt_d    = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                sa_A  = a_q[0];
                sa_B  = b_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cin_q     <= 1'b0;
            sum_out_q <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cin_q <= cin;
            end
            if (last_shift) begin
                sum_out_q <= sum_final;
                cout_q    <= carry_out;
            end
        end
    end

    assign sum  = sum_out_q;
    assign cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
    // During the final SHIFT cycle sa_COUT is the carry into the MSB, so
    // overflow is that carry XOR the carry out of the MSB.
    logic ovf_q;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last_shift) begin
            ovf_q <= sa_COUT ^ carry_out;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule : serial_add_seq
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_seq
// Purpose  : Self-checking bench for serial_add_seq (WIDTH=8) with a
//            behavioural bit-serial adder cell attached to the sa_* ports.
//            ovf checks are active when SERIAL_ADD_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_seq;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             rst;
    logic             req;
    logic [WIDTH-1:0] op_a, op_b;
    logic             cin;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;
    logic             sa_A, sa_B, sa_CIN, sa_start;
    logic             sa_S, sa_COUT;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    // Behavioural adder cell: carry flop, combinational sum.
    logic carry_m;
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)           carry_m <= 1'b0;
        else if (sa_start) carry_m <= sa_CIN;
        else               carry_m <= (sa_A & sa_B) | (sa_A & carry_m) | (sa_B & carry_m);
    end
    assign sa_S    = sa_A ^ sa_B ^ carry_m;
    assign sa_COUT = carry_m;

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .rst      (rst),
        .req      (req),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .sa_A     (sa_A),
        .sa_B     (sa_B),
        .sa_CIN   (sa_CIN),
        .sa_start (sa_start),
        .sa_S     (sa_S),
        .sa_COUT  (sa_COUT)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issues one request and follows it until busy drops (bounded).
    // i counts cycles from the accept edge: 0 = LOAD, WIDTH+1 = DONE.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic c,
                           output logic [7:0] s, output logic co, output logic ov,
                           output int lat, output int busy_cnt, output int done_cnt,
                           output logic ld_start, output logic ld_cin);
        lat = -1; busy_cnt = 0; done_cnt = 0; s = '0; co = 1'b0; ov = 1'b0;
        ld_start = 1'b0; ld_cin = 1'b0;
        op_a = a; op_b = b; cin = c; req = 1'b1;
        step();
        req = 1'b0;
        // Later operand changes must not matter.
        op_a = ~a; op_b = ~b; cin = ~c;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) begin
                ld_start = sa_start;
                ld_cin   = sa_CIN;
            end
            if (busy) busy_cnt++;
            if (done) begin
                if (done_cnt == 0) begin
                    lat = i; s = sum; co = cout;
`ifdef SERIAL_ADD_OVF_EN
                    ov = ovf;
`endif
                end
                done_cnt++;
            end
            if (!busy) break;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        step(); step();
        n_checks++;
        if ({busy, done, cout, sa_A, sa_B, sa_CIN, sa_start} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {busy, done, cout, sa_A, sa_B, sa_CIN, sa_start});
        end
        n_checks++;
        if (sum !== 8'h00) begin
            n_fail++; $display("FAIL reset_sum: got %h expected 00", sum);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [7:0] s; logic co, ov, lds, ldc; int lat, bc, dc;
        run_txn(8'h35, 8'h4A, 1'b0, s, co, ov, lat, bc, dc, lds, ldc);
        n_checks++;
        if (s !== 8'h7F || co !== 1'b0) begin
            n_fail++; $display("FAIL basic_sum: got %h/%b expected 7f/0", s, co);
        end
        n_checks++;
        if (lat !== 9) begin
            n_fail++; $display("FAIL basic_latency: got %0d expected 9", lat);
        end
        n_checks++;
        if (bc !== 10) begin
            n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 10", bc);
        end
        n_checks++;
        if (dc !== 1) begin
            n_fail++; $display("FAIL basic_done_count: got %0d expected 1", dc);
        end
        n_checks++;
        if (lds !== 1'b1 || ldc !== 1'b0) begin
            n_fail++; $display("FAIL basic_load: sa_start=%b sa_CIN=%b expected 1 0", lds, ldc);
        end
        n_checks++;
        if (sa_A !== 1'b0 || sa_B !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle_sa: sa_A=%b sa_B=%b expected 0 0", sa_A, sa_B);
        end
    endtask

    task automatic test_carry();
        logic [7:0] s; logic co, ov, lds, ldc; int lat, bc, dc;
        run_txn(8'hFF, 8'h01, 1'b0, s, co, ov, lat, bc, dc, lds, ldc);
        n_checks++;
        if (s !== 8'h00 || co !== 1'b1) begin
            n_fail++; $display("FAIL carry_ff01: got %h/%b expected 00/1", s, co);
        end
`ifdef SERIAL_ADD_OVF_EN
        n_checks++;
        if (ov !== 1'b0) begin
            n_fail++; $display("FAIL carry_ff01_ovf: got %b expected 0", ov);
        end
`endif
        run_txn(8'h00, 8'h00, 1'b1, s, co, ov, lat, bc, dc, lds, ldc);
        n_checks++;
        if (s !== 8'h01 || co !== 1'b0) begin
            n_fail++; $display("FAIL carry_cin: got %h/%b expected 01/0", s, co);
        end
        n_checks++;
        if (ldc !== 1'b1) begin
            n_fail++; $display("FAIL carry_load_cin: sa_CIN got %b expected 1", ldc);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] s; logic co, ov, lds, ldc; int lat, bc, dc;
        run_txn(8'h7F, 8'h01, 1'b0, s, co, ov, lat, bc, dc, lds, ldc);
        n_checks++;
        if (s !== 8'h80 || co !== 1'b0) begin
            n_fail++; $display("FAIL ovf_7f01: got %h/%b expected 80/0", s, co);
        end
`ifdef SERIAL_ADD_OVF_EN
        n_checks++;
        if (ov !== 1'b1) begin
            n_fail++; $display("FAIL ovf_7f01_ovf: got %b expected 1", ov);
        end
`endif
        run_txn(8'h80, 8'h80, 1'b0, s, co, ov, lat, bc, dc, lds, ldc);
        n_checks++;
        if (s !== 8'h00 || co !== 1'b1) begin
            n_fail++; $display("FAIL ovf_8080: got %h/%b expected 00/1", s, co);
        end
`ifdef SERIAL_ADD_OVF_EN
        n_checks++;
        if (ov !== 1'b1) begin
            n_fail++; $display("FAIL ovf_8080_ovf: got %b expected 1", ov);
        end
`endif
    endtask

    task automatic test_ignore_req();
        int dc = 0; logic [7:0] s = '0; logic co = 1'b0;
        op_a = 8'hC8; op_b = 8'h50; cin = 1'b0; req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 1; i <= 3; i++) step();
        // Third cycle after accept is mid-SHIFT: try to start another add.
        op_a = 8'h11; op_b = 8'h11; cin = 1'b1; req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 4; i <= 25; i++) begin
            if (done) begin
                if (dc == 0) begin s = sum; co = cout; end
                dc++;
            end
            step();
        end
        n_checks++;
        if (s !== 8'h18 || co !== 1'b1) begin
            n_fail++; $display("FAIL ignore_result: got %h/%b expected 18/1", s, co);
        end
        n_checks++;
        if (dc !== 1) begin
            n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", dc);
        end
        n_checks++;
        if (busy !== 1'b0 || sum !== 8'h18) begin
            n_fail++; $display("FAIL ignore_no_queue: busy=%b sum=%h expected 0 18", busy, sum);
        end
    endtask

    task automatic test_reset_abort();
        int dc = 0;
        logic [7:0] s; logic co, ov, lds, ldc; int lat, bc, tdc;
        op_a = 8'hFF; op_b = 8'hFF; cin = 1'b0; req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 1; i <= 3; i++) step();
        n_checks++;
        if (busy !== 1'b1 || sa_A !== 1'b1 || cout !== 1'b1) begin
            n_fail++; $display("FAIL abort_pre: busy=%b sa_A=%b cout=%b expected 1 1 1", busy, sa_A, cout);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, cout, sa_A, sa_B, sa_CIN, sa_start} !== 7'b0 || sum !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_immediate: ctrl=%b sum=%h expected 0000000 00",
                     {busy, done, cout, sa_A, sa_B, sa_CIN, sa_start}, sum);
        end
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) dc++;
            step();
        end
        n_checks++;
        if (dc !== 0) begin
            n_fail++; $display("FAIL abort_no_done: active cycles got %0d expected 0", dc);
        end
        run_txn(8'h0F, 8'h01, 1'b0, s, co, ov, lat, bc, tdc, lds, ldc);
        n_checks++;
        if (s !== 8'h10 || co !== 1'b0 || lat !== 9) begin
            n_fail++; $display("FAIL abort_recover: got %h/%b lat %0d expected 10/0 lat 9", s, co, lat);
        end
    endtask

    task automatic test_back_to_back();
        int         n = 0;
        int         idx[2];
        logic [7:0] dsum[2];
        idx[0] = -1; idx[1] = -1; dsum[0] = '0; dsum[1] = '0;
        op_a = 8'h01; op_b = 8'h02; cin = 1'b0; req = 1'b1;
        step();
        op_a = 8'h03; op_b = 8'h04;
        for (int i = 0; i <= 24; i++) begin
            if (done && n < 2) begin
                idx[n] = i; dsum[n] = sum; n++;
            end
            if (n == 2) req = 1'b0;
            step();
        end
        req = 1'b0;
        n_checks++;
        if (n !== 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 2", n);
        end
        n_checks++;
        if (idx[0] !== 9 || dsum[0] !== 8'h03) begin
            n_fail++; $display("FAIL b2b_first: cycle %0d sum %h expected 9 03", idx[0], dsum[0]);
        end
        n_checks++;
        if (idx[1] - idx[0] !== 11 || dsum[1] !== 8'h07) begin
            n_fail++; $display("FAIL b2b_second: gap %0d sum %h expected 11 07", idx[1] - idx[0], dsum[1]);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: busy got %b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_overflow();
        test_ignore_req();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_add_seq
`default_nettype wire
